// File: rtl/regfile_pkg.sv
// Shared register-file constants and the default writeback source numbering.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Default requester slots on the writeback arbiter.
  typedef enum logic [1:0] {
    WB_ALU     = 2'd0,
    WB_MULTDIV = 2'd1,
    WB_LOAD    = 2'd2
  } wb_src_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner,
  output logic               any
);

  localparam logic [PTR_W:0] NUM_W = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0] idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= NUM_W) begin
        idx = idx - NUM_W;
      end
      if (!any && req[idx[PTR_W-1:0]]) begin
        any                     = 1'b1;
        grant[idx[PTR_W-1:0]]   = 1'b1;
        winner                  = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between writeback
// sources; registers the winning write one cycle after grant.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ctrl_write_enable,
  output logic [ADDR_W-1:0]         ctrl_write_reg,
  output logic [DATA_W-1:0]         data_write_reg,
  output logic                      wb_conflict
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(REG_ZERO);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               conflict_q, conflict_d;

  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   winner;
  logic               any;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic [ADDR_W-1:0]  addr_win;
  logic [DATA_W-1:0]  data_win;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Masking the requests (rather than the grant) keeps req_ready and the
  // transfer strobe consistent: nothing is granted in reset or under hold.
  assign req_eff = (reset_n && !hold) ? req_valid : '0;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req    (req_eff),
    .ptr    (rr_ptr_q),
    .grant  (grant),
    .winner (winner),
    .any    (any)
  );

  assign req_ready = grant;
  assign addr_win  = addr_arr[winner];
  assign data_win  = data_arr[winner];

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (any) begin
      rr_ptr_d  = (winner == PTR_LAST) ? '0 : winner + PTR_W'(1);
      wr_en_d   = (addr_win != ADDR_ZERO);
      wr_reg_d  = addr_win;
      wr_data_d = data_win;
    end
  end

  // Same-destination detection looks at raw valids, independent of hold.
  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = i + 1; j < NUM_REQ; j++) begin
        if (req_valid[i] && req_valid[j] &&
            (addr_arr[i] == addr_arr[j]) && (addr_arr[i] != ADDR_ZERO)) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
      conflict_q <= conflict_d;
    end
  end

  assign ctrl_write_enable = wr_en_q;
  assign ctrl_write_reg    = wr_reg_q;
  assign data_write_reg    = wr_data_q;
  assign wb_conflict       = conflict_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            ctrl_write_enable;
  logic [AW-1:0]   ctrl_write_reg;
  logic [DW-1:0]   data_write_reg;
  logic            wb_conflict;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .hold              (hold),
    .req_valid         (req_valid),
    .req_addr          (req_addr),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .ctrl_write_enable (ctrl_write_enable),
    .ctrl_write_reg    (ctrl_write_reg),
    .data_write_reg    (data_write_reg),
    .wb_conflict       (wb_conflict)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Advance past the next rising edge; inputs then change, outputs are stable.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [AW-1:0] r,
                        input logic [DW-1:0] d);
    chk({tag, "_en"},   64'(ctrl_write_enable), 64'(en));
    chk({tag, "_reg"},  64'(ctrl_write_reg),    64'(r));
    chk({tag, "_data"}, 64'(data_write_reg),    64'(d));
  endtask

  localparam logic [DW-1:0] DA = 32'hAAAA_0001;
  localparam logic [DW-1:0] DB = 32'hBBBB_0002;
  localparam logic [DW-1:0] DC = 32'hCCCC_0003;

  initial begin
    logic [DW-1:0] exp_d [N];
    exp_d[0] = DA; exp_d[1] = DB; exp_d[2] = DC;

    // 1. Reset with every source requesting
    reset_n   = 1'b0;
    hold      = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    set_src(0, 5'd1, DA);
    set_src(1, 5'd2, DB);
    set_src(2, 5'd3, DC);
    #2;
    chk("rst_ready0", 64'(req_ready), 64'd0);
    for (int c = 0; c < 2; c++) begin
      cyc();
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk_wr("rst", 1'b0, 5'd0, 32'd0);
      chk("rst_conflict", 64'(wb_conflict), 64'd0);
    end
    reset_n = 1'b1;
    #1;

    // 2. Round-robin over three always-valid sources
    for (int k = 0; k < 6; k++) begin
      chk("rr_ready", 64'(req_ready), 64'(3'b001 << (k % 3)));
      cyc();
      chk_wr("rr", 1'b1, AW'((k % 3) + 1), exp_d[k % 3]);
      chk("rr_conflict", 64'(wb_conflict), 64'd0);
    end

    // 3. Write to $r0 handshakes but is suppressed
    req_valid = 3'b010;
    set_src(1, 5'd0, 32'hDEAD_BEEF);
    #1;
    chk("r0_ready", 64'(req_ready), 64'b010);
    cyc();
    chk_wr("r0", 1'b0, 5'd0, 32'hDEAD_BEEF);
    // probe pointer (expect 2) without letting an edge see this request mix
    set_src(1, 5'd2, DB);
    req_valid = 3'b111;
    #1;
    chk("r0_ptr_probe", 64'(req_ready), 64'b100);

    // 4. Hold freezes grants and pointer
    hold      = 1'b1;
    req_valid = 3'b011;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("hold_ready", 64'(req_ready), 64'd0);
      cyc();
      chk("hold_en", 64'(ctrl_write_enable), 64'd0);
    end
    hold = 1'b0;
    #1;
    chk("unhold_ready", 64'(req_ready), 64'b001);
    cyc();
    chk_wr("unhold", 1'b1, 5'd1, DA);
    req_valid = 3'b010;
    #1;
    chk("unhold_ready2", 64'(req_ready), 64'b010);
    cyc();
    chk_wr("unhold2", 1'b1, 5'd2, DB);

    // bring pointer back to 0 via source 2
    req_valid = 3'b100;
    #1;
    chk("wrap_ready", 64'(req_ready), 64'b100);
    cyc();
    chk_wr("wrap", 1'b1, 5'd3, DC);

    // 5. Two sources to the same register
    req_valid = 3'b101;
    set_src(0, 5'd7, 32'd5);
    set_src(2, 5'd7, 32'd9);
    #1;
    chk("cf_ready0", 64'(req_ready), 64'b001);
    cyc();
    chk_wr("cf0", 1'b1, 5'd7, 32'd5);
    chk("cf0_conflict", 64'(wb_conflict), 64'd1);
    req_valid = 3'b100;
    #1;
    chk("cf_ready2", 64'(req_ready), 64'b100);
    cyc();
    chk_wr("cf2", 1'b1, 5'd7, 32'd9);
    chk("cf2_conflict", 64'(wb_conflict), 64'd0);

    // 6. Reset in the cycle after a grant drops the registered write
    req_valid = 3'b010;
    set_src(1, 5'd4, 32'h0000_0044);
    #1;
    chk("mr_ready", 64'(req_ready), 64'b010);
    cyc();
    reset_n   = 1'b0;
    req_valid = 3'b000;
    #1;
    chk("mr_ready_rst", 64'(req_ready), 64'd0);
    cyc();
    chk_wr("mr", 1'b0, 5'd0, 32'd0);
    reset_n   = 1'b1;
    req_valid = 3'b111;
    set_src(0, 5'd1, DA);
    set_src(1, 5'd2, DB);
    set_src(2, 5'd3, DC);
    #1;
    chk("mr_ptr_reset", 64'(req_ready), 64'b001);
    cyc();
    chk_wr("mr_after", 1'b1, 5'd1, DA);
    req_valid = 3'b000;
    #1;
    chk("idle_ready", 64'(req_ready), 64'd0);
    cyc();
    chk("idle_en", 64'(ctrl_write_enable), 64'd0);
    chk("idle_reg_hold", 64'(ctrl_write_reg), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
